// File: rtl/temp_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_disp_pkg
// Description : Shared definitions for the temperature display scanner:
//               7-segment codes (a..g on bits 0..6), scan FSM state encoding
//               and the digit-content select used by the segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package temp_disp_pkg;

  localparam logic [6:0] c_SEG_0     = 7'h3F;
  localparam logic [6:0] c_SEG_1     = 7'h06;
  localparam logic [6:0] c_SEG_2     = 7'h5B;
  localparam logic [6:0] c_SEG_3     = 7'h4F;
  localparam logic [6:0] c_SEG_4     = 7'h66;
  localparam logic [6:0] c_SEG_5     = 7'h6D;
  localparam logic [6:0] c_SEG_6     = 7'h7D;
  localparam logic [6:0] c_SEG_7     = 7'h07;
  localparam logic [6:0] c_SEG_8     = 7'h7F;
  localparam logic [6:0] c_SEG_9     = 7'h6F;
  localparam logic [6:0] c_SEG_DASH  = 7'h40;
  localparam logic [6:0] c_SEG_E     = 7'h79;
  localparam logic [6:0] c_SEG_BLANK = 7'h00;

  // Scan slots: SLOT0 drives the ones digit, SLOT2 the hundreds/sign digit.
  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } scan_state_e;

  // What the decoder shows for the digit currently being scanned.
  typedef enum logic [1:0] {
    SEL_DIGIT = 2'd0,
    SEL_BLANK = 2'd1,
    SEL_DASH  = 2'd2,
    SEL_ERR   = 2'd3
  } dig_sel_e;

endpackage
`default_nettype wire

// File: rtl/temp_seg_lut.sv
`default_nettype none
// ============================================================================
// Module      : temp_seg_lut
// Description : Combinational 7-segment decoder. Shows a BCD digit, blank,
//               dash or 'E' depending on the select input.
// Ports       : code_i - BCD digit (used only when sel_i = SEL_DIGIT)
//               sel_i  - content select
//               seg_o  - segments a..g on bits 0..6, active-high
// Revision    : 1.0 - initial release
// ============================================================================
module temp_seg_lut
  import temp_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  dig_sel_e   sel_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = c_SEG_BLANK;
    case (sel_i)
      SEL_DIGIT: begin
        case (code_i)
          4'd0:    seg_o = c_SEG_0;
          4'd1:    seg_o = c_SEG_1;
          4'd2:    seg_o = c_SEG_2;
          4'd3:    seg_o = c_SEG_3;
          4'd4:    seg_o = c_SEG_4;
          4'd5:    seg_o = c_SEG_5;
          4'd6:    seg_o = c_SEG_6;
          4'd7:    seg_o = c_SEG_7;
          4'd8:    seg_o = c_SEG_8;
          4'd9:    seg_o = c_SEG_9;
          // Non-BCD codes are routed to SEL_ERR upstream; blank is a safe fallback.
          default: seg_o = c_SEG_BLANK;
        endcase
      end
      SEL_BLANK: seg_o = c_SEG_BLANK;
      SEL_DASH:  seg_o = c_SEG_DASH;
      SEL_ERR:   seg_o = c_SEG_E;
      default:   seg_o = c_SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/temp_disp_scan.sv
`default_nettype none
// ============================================================================
// Module      : temp_disp_scan
// Description : Three-digit multiplexed 7-segment temperature display.
//               Accepts signed BCD samples through a valid/ready handshake
//               into a pending buffer, promotes them to the displayed value
//               on frame boundaries, scans the digits with one dead cycle per
//               slot and shows dashes when the data goes stale.
// Ports       : SYSCLK, RSTN (async, active-low)
//               sample_valid/sample_ready     - input handshake
//               sample_sign/hund/tens/ones    - signed BCD sample
//               seg[6:0], dig_en[2:0], stale  - registered display outputs
// Revision    : 1.0 - initial release
// ============================================================================
module temp_disp_scan
  import temp_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int STALE_FRAMES = 255
) (
  input  logic       SYSCLK,
  input  logic       RSTN,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       sample_sign,
  input  logic [3:0] sample_hund,
  input  logic [3:0] sample_tens,
  input  logic [3:0] sample_ones,
  output logic [6:0] seg,
  output logic [2:0] dig_en,
  output logic       stale
);

  localparam int             c_CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]     c_STALE_MAX = 8'(STALE_FRAMES);

  // Scan FSM
  scan_state_e          state_q, state_d;
  logic [c_CNT_W-1:0]   slot_cnt_q, slot_cnt_d;

  // Sample buffers
  logic       pend_full_q;
  logic       pend_sign_q;
  logic [3:0] pend_hund_q, pend_tens_q, pend_ones_q;
  logic       act_sign_q;
  logic [3:0] act_hund_q, act_tens_q, act_ones_q;
  logic       never_valid_q;
  logic [7:0] stale_cnt_q;

  // Output registers
  logic [6:0] seg_q;
  logic [2:0] dig_en_q;
  logic       stale_q;

  logic       w_last, w_boundary, w_accept, w_stale, w_err, w_dead;
  logic [3:0] w_code;
  dig_sel_e   w_sel;
  logic [6:0] w_lut_seg;
  logic [2:0] w_onehot;

  // ---------------------------------------------------------------- scan FSM
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= SLOT0;
      slot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q + 1'b1;
    w_last     = (slot_cnt_q == c_CNT_MAX);
    w_boundary = w_last && (state_q == SLOT2);
    w_dead     = (slot_cnt_q == '0);
    w_onehot   = 3'b001;
    case (state_q)
      SLOT0:   w_onehot = 3'b001;
      SLOT1:   w_onehot = 3'b010;
      default: w_onehot = 3'b100;
    endcase
    if (w_last) begin
      slot_cnt_d = '0;
      case (state_q)
        SLOT0:   state_d = SLOT1;
        SLOT1:   state_d = SLOT2;
        default: state_d = SLOT0;
      endcase
    end
  end

  // --------------------------------------------------------------- handshake
  // Ready depends only on the pending flag, so a held sample blocks new ones
  // even on the boundary cycle where it is being promoted.
  assign sample_ready = ~pend_full_q;
  assign w_accept     = sample_valid & ~pend_full_q;

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      pend_full_q   <= 1'b0;
      pend_sign_q   <= 1'b0;
      pend_hund_q   <= '0;
      pend_tens_q   <= '0;
      pend_ones_q   <= '0;
      act_sign_q    <= 1'b0;
      act_hund_q    <= '0;
      act_tens_q    <= '0;
      act_ones_q    <= '0;
      never_valid_q <= 1'b1;
      stale_cnt_q   <= '0;
    end else begin
      if (w_accept) begin
        pend_full_q <= 1'b1;
        pend_sign_q <= sample_sign;
        pend_hund_q <= sample_hund;
        pend_tens_q <= sample_tens;
        pend_ones_q <= sample_ones;
      end
      if (w_boundary) begin
        if (pend_full_q) begin
          pend_full_q   <= 1'b0;
          act_sign_q    <= pend_sign_q;
          act_hund_q    <= pend_hund_q;
          act_tens_q    <= pend_tens_q;
          act_ones_q    <= pend_ones_q;
          never_valid_q <= 1'b0;
          stale_cnt_q   <= '0;
        end else if (stale_cnt_q != c_STALE_MAX) begin
          stale_cnt_q   <= stale_cnt_q + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------- digit content
  assign w_stale = never_valid_q || (stale_cnt_q == c_STALE_MAX);
  assign w_err   = (act_sign_q && (act_hund_q != 4'd0)) ||
                   (act_hund_q > 4'd9) || (act_tens_q > 4'd9) || (act_ones_q > 4'd9);

  always_comb begin
    w_code = act_ones_q;
    w_sel  = SEL_DIGIT;
    case (state_q)
      SLOT0: begin
        w_code = act_ones_q;
        w_sel  = SEL_DIGIT;
      end
      SLOT1: begin
        w_code = act_tens_q;
        // Leading-zero suppression: tens blank only when hundreds is also 0.
        w_sel  = ((act_hund_q == 4'd0) && (act_tens_q == 4'd0)) ? SEL_BLANK : SEL_DIGIT;
      end
      default: begin
        w_code = act_hund_q;
        if (act_sign_q)                w_sel = SEL_DASH;
        else if (act_hund_q == 4'd0)   w_sel = SEL_BLANK;
        else                           w_sel = SEL_DIGIT;
      end
    endcase
    // Stale dashes take precedence over the error display.
    if (w_err)   w_sel = SEL_ERR;
    if (w_stale) w_sel = SEL_DASH;
  end

  temp_seg_lut u_seg_lut (
    .code_i (w_code),
    .sel_i  (w_sel),
    .seg_o  (w_lut_seg)
  );

  // ------------------------------------------------------------- outputs
  // First cycle of each slot is dead time so the digit drivers can switch.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      seg_q    <= c_SEG_BLANK;
      dig_en_q <= 3'b000;
      stale_q  <= 1'b1;
    end else begin
      seg_q    <= w_dead ? c_SEG_BLANK : w_lut_seg;
      dig_en_q <= w_dead ? 3'b000 : w_onehot;
      stale_q  <= w_stale;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;
  assign stale  = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_disp_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_disp_scan
// Description : Self-checking bench for temp_disp_scan (REFRESH_DIV=4,
//               STALE_FRAMES=3). Expected frames are queued when samples are
//               sent and compared against captured display frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_disp_scan;

  localparam int c_DIV    = 4;
  localparam int c_STALE  = 3;
  localparam int c_BUDGET = 60;

  logic       SYSCLK = 1'b0;
  logic       RSTN   = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       sample_sign  = 1'b0;
  logic [3:0] sample_hund  = '0;
  logic [3:0] sample_tens  = '0;
  logic [3:0] sample_ones  = '0;
  logic [6:0] seg;
  logic [2:0] dig_en;
  logic       stale;

  typedef struct packed {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
    logic       st;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 SYSCLK = ~SYSCLK;

  temp_disp_scan #(.REFRESH_DIV(c_DIV), .STALE_FRAMES(c_STALE)) dut (
    .SYSCLK       (SYSCLK),
    .RSTN         (RSTN),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_sign  (sample_sign),
    .sample_hund  (sample_hund),
    .sample_tens  (sample_tens),
    .sample_ones  (sample_ones),
    .seg          (seg),
    .dig_en       (dig_en),
    .stale        (stale)
  );

  // Capture the next full frame starting at the first active SLOT0 cycle.
  // ok drops if the dead-time / one-hot pattern is wrong or no frame appears.
  task automatic capture_frame(output frame_t f, output bit ok);
    logic [2:0] prev;
    bit found;
    ok = 1'b1; found = 1'b0; f = '0;
    prev = dig_en;
    for (int n = 0; n < c_BUDGET && !found; n++) begin
      @(negedge SYSCLK);
      if (prev == 3'b000 && dig_en == 3'b001) found = 1'b1;
      else prev = dig_en;
    end
    if (!found) begin
      ok = 1'b0;
      return;
    end
    f.st = stale;
    f.s0 = seg;
    for (int i = 0; i < c_DIV - 2; i++) begin
      @(negedge SYSCLK);
      if (dig_en !== 3'b001 || seg !== f.s0) ok = 1'b0;
    end
    @(negedge SYSCLK);
    if (dig_en !== 3'b000 || seg !== 7'h00) ok = 1'b0;
    @(negedge SYSCLK);
    f.s1 = seg;
    if (dig_en !== 3'b010) ok = 1'b0;
    for (int i = 0; i < c_DIV - 2; i++) begin
      @(negedge SYSCLK);
      if (dig_en !== 3'b010 || seg !== f.s1) ok = 1'b0;
    end
    @(negedge SYSCLK);
    if (dig_en !== 3'b000 || seg !== 7'h00) ok = 1'b0;
    @(negedge SYSCLK);
    f.s2 = seg;
    if (dig_en !== 3'b100) ok = 1'b0;
    for (int i = 0; i < c_DIV - 2; i++) begin
      @(negedge SYSCLK);
      if (dig_en !== 3'b100 || seg !== f.s2) ok = 1'b0;
    end
  endtask

  // Wait for the start of a visible SLOT2; the frame boundary follows it.
  task automatic wait_slot2_rise(output bit ok);
    logic [2:0] prev;
    ok = 1'b0;
    prev = dig_en;
    for (int n = 0; n < c_BUDGET && !ok; n++) begin
      @(negedge SYSCLK);
      if (dig_en == 3'b100 && prev != 3'b100) ok = 1'b1;
      else prev = dig_en;
    end
  endtask

  task automatic send_sample(input logic sg, input logic [3:0] h, t, o,
                             input logic [6:0] e0, e1, e2);
    bit done;
    done = 1'b0;
    @(negedge SYSCLK);
    sample_valid = 1'b1;
    sample_sign = sg; sample_hund = h; sample_tens = t; sample_ones = o;
    for (int n = 0; n < c_BUDGET && !done; n++) begin
      if (sample_ready) begin
        sb.push_back(frame_t'{e0, e1, e2, 1'b0});
        done = 1'b1;
      end
      @(negedge SYSCLK);
    end
    sample_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: sample %0b/%h%h%h not accepted within %0d cycles", sg, h, t, o, c_BUDGET);
    end
  endtask

  task automatic test_reset;
    frame_t f, e;
    bit ok;
    RSTN = 1'b0;
    repeat (3) @(negedge SYSCLK);
    checks += 4;
    if (seg !== 7'h00)     begin errors++; $display("FAIL reset_seg: observed %h required 00", seg); end
    if (dig_en !== 3'b000) begin errors++; $display("FAIL reset_dig_en: observed %b required 000", dig_en); end
    if (stale !== 1'b1)    begin errors++; $display("FAIL reset_stale: observed %b required 1", stale); end
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: observed %b required 1", sample_ready); end
    RSTN = 1'b1;
    sb.push_back(frame_t'{7'h40, 7'h40, 7'h40, 1'b1});
    capture_frame(f, ok);
    e = sb.pop_front();
    checks += 6;
    if (!ok)          begin errors++; $display("FAIL reset_frame_shape: observed bad scan pattern, required dead+3 active per slot"); end
    if (f.s0 !== e.s0) begin errors++; $display("FAIL reset_slot0: observed %h required %h", f.s0, e.s0); end
    if (f.s1 !== e.s1) begin errors++; $display("FAIL reset_slot1: observed %h required %h", f.s1, e.s1); end
    if (f.s2 !== e.s2) begin errors++; $display("FAIL reset_slot2: observed %h required %h", f.s2, e.s2); end
    if (f.st !== e.st) begin errors++; $display("FAIL reset_stale_frame: observed %b required %b", f.st, e.st); end
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_idle: observed %b required 1", sample_ready); end
  endtask

  // Sends one sample, waits past its promotion boundary and checks the frame.
  task automatic test_display(input string name, input logic sg, input logic [3:0] h, t, o,
                              input logic [6:0] e0, e1, e2);
    frame_t f, e;
    bit ok, wok;
    send_sample(sg, h, t, o, e0, e1, e2);
    wait_slot2_rise(wok);
    capture_frame(f, ok);
    checks += 6;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s_scoreboard: observed empty queue, required one entry", name);
      return;
    end
    e = sb.pop_front();
    if (!(ok && wok))  begin errors++; $display("FAIL %s_frame_shape: observed bad scan pattern, required dead+3 active per slot", name); end
    if (f.s0 !== e.s0) begin errors++; $display("FAIL %s_slot0: observed %h required %h", name, f.s0, e.s0); end
    if (f.s1 !== e.s1) begin errors++; $display("FAIL %s_slot1: observed %h required %h", name, f.s1, e.s1); end
    if (f.s2 !== e.s2) begin errors++; $display("FAIL %s_slot2: observed %h required %h", name, f.s2, e.s2); end
    if (f.st !== e.st) begin errors++; $display("FAIL %s_stale: observed %b required %b", name, f.st, e.st); end
  endtask

  task automatic test_back_to_back;
    frame_t f, e;
    bit ok, done, wok;
    int waited;
    done = 1'b0; waited = 0;
    @(negedge SYSCLK);
    sample_valid = 1'b1;
    sample_sign = 1'b0; sample_hund = 4'd3; sample_tens = 4'd0; sample_ones = 4'd8;
    for (int n = 0; n < c_BUDGET && !done; n++) begin
      if (sample_ready) begin
        sb.push_back(frame_t'{7'h7F, 7'h3F, 7'h4F, 1'b0});
        done = 1'b1;
      end
      @(negedge SYSCLK);
    end
    // Second sample offered immediately with valid held high.
    sample_sign = 1'b1; sample_hund = 4'd0; sample_tens = 4'd4; sample_ones = 4'd2;
    done = 1'b0;
    for (int n = 0; n < c_BUDGET && !done; n++) begin
      if (sample_ready) begin
        done = 1'b1;
        sb.push_back(frame_t'{7'h5B, 7'h66, 7'h40, 1'b0});
        checks++;
        // Accepting cycle is the first SLOT0 cycle: display still shows SLOT2.
        if (dig_en !== 3'b100) begin errors++; $display("FAIL b2b_accept_slot: observed dig_en %b required 100", dig_en); end
      end else begin
        waited++;
      end
      @(negedge SYSCLK);
    end
    sample_valid = 1'b0;
    checks += 3;
    if (!done)       begin errors++; $display("FAIL b2b_second_accept: observed no accept, required accept after boundary"); end
    if (waited < 1)  begin errors++; $display("FAIL b2b_ready_low: observed %0d blocked cycles, required >=1", waited); end
    if (dig_en !== 3'b000) begin errors++; $display("FAIL b2b_after_accept: observed dig_en %b required 000", dig_en); end
    // First sample was promoted on the boundary just passed.
    for (int k = 0; k < 2; k++) begin
      if (k == 1) wait_slot2_rise(wok);
      else wok = 1'b1;
      capture_frame(f, ok);
      checks += 5;
      if (sb.size() == 0) begin
        errors++; $display("FAIL b2b_scoreboard: observed empty queue, required entry %0d", k);
        return;
      end
      e = sb.pop_front();
      if (!(ok && wok))  begin errors++; $display("FAIL b2b_frame_shape%0d: observed bad scan pattern", k); end
      if (f.s0 !== e.s0) begin errors++; $display("FAIL b2b_slot0_%0d: observed %h required %h", k, f.s0, e.s0); end
      if (f.s1 !== e.s1) begin errors++; $display("FAIL b2b_slot1_%0d: observed %h required %h", k, f.s1, e.s1); end
      if (f.s2 !== e.s2) begin errors++; $display("FAIL b2b_slot2_%0d: observed %h required %h", k, f.s2, e.s2); end
      if (f.st !== e.st) begin errors++; $display("FAIL b2b_stale_%0d: observed %b required %b", k, f.st, e.st); end
    end
  endtask

  // Invalid BCD shows E; then three frames without samples go stale.
  task automatic test_error_and_stale;
    frame_t f, e;
    bit ok;
    test_display("bad_bcd", 1'b0, 4'd0, 4'hA, 4'd1, 7'h79, 7'h79, 7'h79);
    // Frames after the boundaries with stale counter 1, 2, 3.
    sb.push_back(frame_t'{7'h79, 7'h79, 7'h79, 1'b0});
    sb.push_back(frame_t'{7'h79, 7'h79, 7'h79, 1'b0});
    sb.push_back(frame_t'{7'h40, 7'h40, 7'h40, 1'b1});
    for (int k = 1; k <= c_STALE; k++) begin
      capture_frame(f, ok);
      e = sb.pop_front();
      checks += 5;
      if (!ok)           begin errors++; $display("FAIL stale_frame_shape%0d: observed bad scan pattern", k); end
      if (f.s0 !== e.s0) begin errors++; $display("FAIL stale_slot0_f%0d: observed %h required %h", k, f.s0, e.s0); end
      if (f.s1 !== e.s1) begin errors++; $display("FAIL stale_slot1_f%0d: observed %h required %h", k, f.s1, e.s1); end
      if (f.s2 !== e.s2) begin errors++; $display("FAIL stale_slot2_f%0d: observed %h required %h", k, f.s2, e.s2); end
      if (f.st !== e.st) begin errors++; $display("FAIL stale_flag_f%0d: observed %b required %b", k, f.st, e.st); end
    end
    test_display("neg_hund", 1'b1, 4'd2, 4'd3, 4'd4, 7'h79, 7'h79, 7'h79);
  endtask

  task automatic test_mid_reset;
    frame_t f, e;
    bit ok, wok;
    logic [2:0] prev;
    wok = 1'b0;
    prev = dig_en;
    for (int n = 0; n < c_BUDGET && !wok; n++) begin
      @(negedge SYSCLK);
      if (dig_en == 3'b001 && prev != 3'b001) wok = 1'b1;
      else prev = dig_en;
    end
    sample_valid = 1'b1;
    sample_sign = 1'b0; sample_hund = 4'd1; sample_tens = 4'd1; sample_ones = 4'd1;
    checks++;
    if (!(wok && sample_ready === 1'b1)) begin errors++; $display("FAIL midrst_offer: observed ready %b, required 1 in SLOT0", sample_ready); end
    @(negedge SYSCLK);
    sample_valid = 1'b0;
    wok = 1'b0;
    prev = dig_en;
    for (int n = 0; n < c_BUDGET && !wok; n++) begin
      @(negedge SYSCLK);
      if (dig_en == 3'b010 && prev != 3'b010) wok = 1'b1;
      else prev = dig_en;
    end
    checks++;
    if (!(wok && sample_ready === 1'b0)) begin errors++; $display("FAIL midrst_pending: observed ready %b, required 0 mid-SLOT1", sample_ready); end
    RSTN = 1'b0;
    #1;
    checks += 4;
    if (dig_en !== 3'b000)     begin errors++; $display("FAIL midrst_dig_en: observed %b required 000", dig_en); end
    if (seg !== 7'h00)         begin errors++; $display("FAIL midrst_seg: observed %h required 00", seg); end
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: observed %b required 1", sample_ready); end
    if (stale !== 1'b1)        begin errors++; $display("FAIL midrst_stale: observed %b required 1", stale); end
    @(negedge SYSCLK);
    RSTN = 1'b1;
    // Pending sample was discarded: dashes persist across the next boundary.
    sb.push_back(frame_t'{7'h40, 7'h40, 7'h40, 1'b1});
    sb.push_back(frame_t'{7'h40, 7'h40, 7'h40, 1'b1});
    for (int k = 0; k < 2; k++) begin
      capture_frame(f, ok);
      e = sb.pop_front();
      checks += 5;
      if (!ok)           begin errors++; $display("FAIL midrst_frame_shape%0d: observed bad scan pattern", k); end
      if (f.s0 !== e.s0) begin errors++; $display("FAIL midrst_slot0_%0d: observed %h required %h", k, f.s0, e.s0); end
      if (f.s1 !== e.s1) begin errors++; $display("FAIL midrst_slot1_%0d: observed %h required %h", k, f.s1, e.s1); end
      if (f.s2 !== e.s2) begin errors++; $display("FAIL midrst_slot2_%0d: observed %h required %h", k, f.s2, e.s2); end
      if (f.st !== e.st) begin errors++; $display("FAIL midrst_stale_%0d: observed %b required %b", k, f.st, e.st); end
    end
  endtask

  initial begin
    test_reset();
    test_display("pos025", 1'b0, 4'd0, 4'd2, 4'd5, 7'h6D, 7'h5B, 7'h00);
    test_display("neg007", 1'b1, 4'd0, 4'd0, 4'd7, 7'h07, 7'h00, 7'h40);
    test_display("pos125", 1'b0, 4'd1, 4'd2, 4'd5, 7'h6D, 7'h5B, 7'h06);
    test_back_to_back();
    test_error_and_stale();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
